// File: rtl/vx_dma_cmd_queue_pkg.sv
// Shared DMA command-queue definitions: opcode encoding and sizing helpers.
package vx_dma_cmd_queue_pkg;

  typedef enum logic [1:0] {
    DMA_OP_G2L  = 2'd0,
    DMA_OP_L2G  = 2'd1,
    DMA_OP_WAIT = 2'd2,
    DMA_OP_RSVD = 2'd3
  } dma_op_e;

  // Index width that never collapses to zero for single-entry sets.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dma_cmd_queue_fifo.sv
// First-word-fall-through command FIFO; head entry is visible while not empty.
module vx_dma_cmd_queue_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/vx_dma_cmd_queue.sv
// DMA command front-end: buffers transfers, allocates engine channels and
// tracks per-warp outstanding work to drive the DMA-wait stall.
module vx_dma_cmd_queue
  import vx_dma_cmd_queue_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int QUEUE_SIZE   = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 16,
  localparam int NW_BITS     = clog2_min1(NUM_WARPS),
  localparam int CH_BITS     = clog2_min1(NUM_CHANNELS),
  localparam int CNT_BITS    = $clog2(QUEUE_SIZE + NUM_CHANNELS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [NW_BITS-1:0]    req_wid,
  input  logic [ADDR_WIDTH-1:0] req_gaddr,
  input  logic [ADDR_WIDTH-1:0] req_laddr,
  input  logic [SIZE_WIDTH-1:0] req_size,
  output logic                  eng_valid,
  input  logic                  eng_ready,
  output logic [CH_BITS-1:0]    eng_ch,
  output logic                  eng_dir,
  output logic [ADDR_WIDTH-1:0] eng_gaddr,
  output logic [ADDR_WIDTH-1:0] eng_laddr,
  output logic [SIZE_WIDTH-1:0] eng_size,
  input  logic                  done_valid,
  input  logic [CH_BITS-1:0]    done_ch,
  output logic [NUM_WARPS-1:0]  dma_warp_stall,
  output logic                  busy
);

  typedef struct packed {
    logic [NW_BITS-1:0]    wid;
    logic                  dir;
    logic [ADDR_WIDTH-1:0] gaddr;
    logic [ADDR_WIDTH-1:0] laddr;
    logic [SIZE_WIDTH-1:0] size;
  } dma_cmd_t;

  dma_cmd_t push_cmd, head_cmd;
  logic     fifo_empty, fifo_full;
  logic     is_xfer, is_wait, req_fire, push_en, pop_en;

  assign is_xfer   = (req_op == DMA_OP_G2L) || (req_op == DMA_OP_L2G);
  assign is_wait   = (req_op == DMA_OP_WAIT);
  assign req_ready = is_xfer ? !fifo_full : 1'b1;
  assign req_fire  = req_valid && req_ready;
  assign push_en   = req_fire && is_xfer && (req_size != '0);
  assign push_cmd  = {req_wid, req_op[0], req_gaddr, req_laddr, req_size};

  vx_dma_cmd_queue_fifo #(
    .DATAW ($bits(dma_cmd_t)),
    .DEPTH (QUEUE_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .data_i  (push_cmd),
    .data_o  (head_cmd),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  logic [NUM_CHANNELS-1:0] ch_busy_q, ch_busy_d;
  logic [NW_BITS-1:0]      ch_wid_q [NUM_CHANNELS];
  logic [CH_BITS-1:0]      free_ch, hold_ch_q;
  logic                    any_free, hold_q, done_hit;
  logic [NW_BITS-1:0]      done_wid;
  logic [NUM_WARPS-1:0]    wait_q, wait_d;

  // Lowest-index free channel wins: the downward scan leaves the smallest index.
  always_comb begin
    free_ch  = '0;
    any_free = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (!ch_busy_q[i]) begin
        free_ch  = CH_BITS'(i);
        any_free = 1'b1;
      end
    end
  end

  // A stalled offer keeps its channel even if a lower one frees meanwhile.
  assign eng_ch    = hold_q ? hold_ch_q : free_ch;
  assign eng_valid = !fifo_empty && any_free;
  assign pop_en    = eng_valid && eng_ready;
  assign eng_dir   = head_cmd.dir;
  assign eng_gaddr = head_cmd.gaddr;
  assign eng_laddr = head_cmd.laddr;
  assign eng_size  = head_cmd.size;

  assign done_hit  = done_valid && ch_busy_q[done_ch];
  assign done_wid  = ch_wid_q[done_ch];

  always_comb begin
    ch_busy_d = ch_busy_q;
    if (done_hit) ch_busy_d[done_ch] = 1'b0;
    if (pop_en)   ch_busy_d[eng_ch]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_busy_q <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
      wait_q    <= '0;
    end else begin
      ch_busy_q <= ch_busy_d;
      hold_q    <= eng_valid && !eng_ready;
      hold_ch_q <= eng_ch;
      wait_q    <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pop_en) ch_wid_q[eng_ch] <= head_cmd.wid;
  end

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                inc, dec;

    assign inc = push_en && (req_wid == NW_BITS'(gi));
    assign dec = done_hit && (done_wid == NW_BITS'(gi));

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CNT_BITS'(1);
      else if (dec && !inc) cnt_d = cnt_q - CNT_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    // A wait only latches against the post-update count, so a same-cycle final done wins.
    assign wait_d[gi] = (wait_q[gi] || (req_fire && is_wait && (req_wid == NW_BITS'(gi))))
                        && (cnt_d != '0);
  end

  assign dma_warp_stall = wait_q;
  assign busy           = !fifo_empty || (|ch_busy_q);

  always_ff @(posedge clk) begin
    if (!reset && done_valid) assert (ch_busy_q[done_ch]);
  end

endmodule

// File: tb/tb_vx_dma_cmd_queue.sv
// Directed and randomized checks of vx_dma_cmd_queue against a queue-based model.
module tb_vx_dma_cmd_queue;
  localparam int NW = 4;
  localparam int NC = 4;
  localparam int QS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_wid;
  logic [31:0] req_gaddr, req_laddr;
  logic [15:0] req_size;
  logic        eng_valid;
  logic        eng_ready;
  logic [1:0]  eng_ch;
  logic        eng_dir;
  logic [31:0] eng_gaddr, eng_laddr;
  logic [15:0] eng_size;
  logic        done_valid;
  logic [1:0]  done_ch;
  logic [3:0]  dma_warp_stall;
  logic        busy;

  vx_dma_cmd_queue dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wid(req_wid),
    .req_gaddr(req_gaddr), .req_laddr(req_laddr), .req_size(req_size),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_ch(eng_ch), .eng_dir(eng_dir),
    .eng_gaddr(eng_gaddr), .eng_laddr(eng_laddr), .eng_size(eng_size),
    .done_valid(done_valid), .done_ch(done_ch),
    .dma_warp_stall(dma_warp_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wid;
    int          dir;
    logic [31:0] g;
    logic [31:0] l;
    logic [15:0] size;
  } mcmd_t;

  mcmd_t      mq[$];
  bit         m_busy [NC];
  int         m_owner[NC];
  int         m_out  [NW];
  logic [3:0] m_wait;
  bit         m_hold;
  int         m_hold_ch;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NC; i++) begin m_busy[i] = 0; m_owner[i] = 0; end
    for (int w = 0; w < NW; w++) m_out[w] = 0;
    m_wait = '0; m_hold = 0; m_hold_ch = 0;
  endtask

  task automatic req(input bit v, input int op, input int wid, input int sz);
    req_valid = v; req_op = 2'(op); req_wid = 2'(wid);
    req_gaddr = $urandom; req_laddr = $urandom; req_size = 16'(sz);
  endtask

  task automatic idle();
    req_valid = 0; done_valid = 0;
  endtask

  task automatic done_any();
    done_valid = 0;
    for (int i = 0; i < NC; i++) if (m_busy[i]) begin done_valid = 1; done_ch = 2'(i); break; end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    int    ch;
    bit    anyfree, ev, xfer, exp_ready, exp_busy, acc, disp, dhit;
    mcmd_t c;
    #1;
    xfer = (req_op == 2'd0) || (req_op == 2'd1);
    exp_ready = xfer ? (mq.size() < QS) : 1'b1;
    ch = 0; anyfree = 0; exp_busy = (mq.size() > 0);
    for (int i = 0; i < NC; i++) if (m_busy[i]) exp_busy = 1;
    for (int i = 0; i < NC; i++) if (!m_busy[i]) begin ch = i; anyfree = 1; break; end
    if (m_hold) ch = m_hold_ch;
    ev = (mq.size() > 0) && anyfree;
    check("req_ready", req_ready, exp_ready);
    check("eng_valid", eng_valid, ev);
    if (ev) begin
      check("eng_ch", eng_ch, ch);
      check("eng_dir", eng_dir, mq[0].dir);
      check("eng_gaddr", eng_gaddr, mq[0].g);
      check("eng_laddr", eng_laddr, mq[0].l);
      check("eng_size", eng_size, mq[0].size);
    end
    check("stall", dma_warp_stall, m_wait);
    check("busy", busy, exp_busy);
    acc  = req_valid && exp_ready;
    disp = ev && eng_ready;
    dhit = done_valid && m_busy[done_ch];
    @(posedge clk);
    if (dhit) begin
      m_busy[done_ch] = 0;
      m_out[m_owner[done_ch]]--;
    end
    if (disp) begin
      c = mq.pop_front();
      m_busy[ch] = 1; m_owner[ch] = c.wid;
    end
    if (acc && xfer && req_size != 0) begin
      c.wid = req_wid; c.dir = int'(req_op[0]); c.g = req_gaddr; c.l = req_laddr; c.size = req_size;
      mq.push_back(c);
      m_out[req_wid]++;
    end
    if (acc && req_op == 2'd2 && m_out[req_wid] != 0) m_wait[req_wid] = 1'b1;
    for (int w = 0; w < NW; w++) if (m_out[w] == 0) m_wait[w] = 1'b0;
    m_hold = ev && !eng_ready; m_hold_ch = ch;
    @(negedge clk);
  endtask

  task automatic drain();
    bit idle_m;
    for (int k = 0; k < 200; k++) begin
      idle_m = (mq.size() == 0);
      for (int i = 0; i < NC; i++) if (m_busy[i]) idle_m = 0;
      if (idle_m) break;
      req_valid = 0; eng_ready = 1; done_any(); tick();
    end
    idle(); tick();
    if (mq.size() != 0) begin n_fail++; $display("FAIL drain: queue still holds %0d entries, required 0", mq.size()); end
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; idle(); eng_ready = 1; done_ch = 0;
    req_op = 0; req_wid = 0; req_gaddr = 0; req_laddr = 0; req_size = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    tick(); tick();

    // Single G2L from warp 2.
    req(1, 0, 2, 64); tick();
    idle(); tick();
    check("single_stall_none", dma_warp_stall, 4'b0000);
    tick();
    done_any(); tick();
    idle(); tick(); tick();

    // Five transfers from warp 0; the fifth waits for a freed channel.
    for (int i = 0; i < 5; i++) begin req(1, i % 2, 0, 16 + i); tick(); end
    idle(); tick(); tick(); tick();
    check("fifth_held", eng_valid, 1'b0);
    done_valid = 1; done_ch = 2'd2; tick();
    idle(); tick(); tick();
    drain();

    // WAIT with two outstanding transfers, then WAIT with none.
    req(1, 0, 1, 32); tick();
    req(1, 1, 1, 32); tick();
    req(1, 2, 1, 0); tick();
    idle(); check("wait_set", dma_warp_stall[1], 1'b1);
    done_any(); tick();
    idle(); check("wait_after_first_done", dma_warp_stall[1], 1'b1);
    done_any(); tick();
    idle(); check("wait_cleared", dma_warp_stall[1], 1'b0);
    req(1, 2, 1, 0); tick();
    idle(); tick();
    check("wait_zero_noop", dma_warp_stall[1], 1'b0);

    // Fill the FIFO with the engine refusing dispatch.
    eng_ready = 0;
    for (int i = 0; i < QS; i++) begin req(1, 0, 0, 8 + i); tick(); end
    req(1, 0, 0, 99); tick();
    req(1, 2, 0, 0); tick();
    check("wait_when_full", dma_warp_stall[0], 1'b1);
    eng_ready = 1; req(1, 1, 0, 100); tick();
    tick();
    idle(); tick();
    drain();

    // Same-cycle done and accept for warp 3, WAIT racing the last done, zero size.
    req(1, 0, 3, 40); tick();
    idle(); tick();
    req(1, 2, 3, 0); done_any(); tick();
    idle(); check("wait_vs_last_done", dma_warp_stall[3], 1'b0);
    req(1, 0, 3, 40); tick();
    idle(); tick();
    req(1, 1, 3, 48); done_any(); tick();
    idle(); req(1, 2, 3, 0); tick();
    idle(); check("inc_dec_same_cycle", dma_warp_stall[3], 1'b1);
    drain();
    req(1, 0, 2, 0); tick();
    idle(); tick();
    check("zero_size_dropped", busy, 1'b0);

    // Asynchronous reset with work in flight.
    for (int i = 0; i < 3; i++) begin req(1, 0, 1, 64); tick(); end
    req(1, 2, 1, 0); tick();
    idle(); tick();
    #2 reset = 1;
    #1;
    check("arst_eng_valid", eng_valid, 1'b0);
    check("arst_stall", dma_warp_stall, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_req_ready", req_ready, 1'b1);
    model_reset();
    @(negedge clk); reset = 0;
    req(1, 1, 0, 20); tick();
    idle(); check("post_reset_ch", eng_ch, 2'd0);
    tick();
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      req($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, NW - 1),
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4096));
      eng_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) done_any(); else done_valid = 0;
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_dma_cmd_queue.md
# VX_dma_cmd_queue

Command front-end for the per-core DMA engine. It sits between the SFU DMA unit, which issues decoded DMA instructions from warps, and `VX_dma_engine`, which moves the data. It buffers transfer commands and allocates them to free engine channels. It tracks outstanding transfers per warp and raises a per-warp stall while a warp is blocked on a DMA wait instruction.

## Interface
Parameters:
- NUM_WARPS, `NUM_WARPS: warps per core; NW_BITS = `CLOG2(NUM_WARPS)
- NUM_CHANNELS, 4: engine channels; CH_BITS = `CLOG2(NUM_CHANNELS)
- QUEUE_SIZE, 16: command FIFO depth (power of 2)
- ADDR_WIDTH, 32: global/local byte address width
- SIZE_WIDTH, 16: transfer byte count width
- CNT_BITS (derived): `CLOG2(QUEUE_SIZE+NUM_CHANNELS+1), per-warp outstanding counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- req_valid  in  1  command from SFU DMA unit
- req_ready  out  1  command accepted when valid&&ready
- req_op  in  2  DMA_OP_G2L=0, DMA_OP_L2G=1, DMA_OP_WAIT=2 (3 reserved, accepted and dropped)
- req_wid  in  NW_BITS  issuing warp
- req_gaddr, req_laddr  in  ADDR_WIDTH  global / local byte address
- req_size  in  SIZE_WIDTH  bytes
- eng_valid  out  1  dispatch to engine
- eng_ready  in  1  engine accepts dispatch
- eng_ch  out  CH_BITS  allocated channel
- eng_dir  out  1  0=G2L, 1=L2G
- eng_gaddr, eng_laddr  out  ADDR_WIDTH
- eng_size  out  SIZE_WIDTH
- done_valid  in  1  engine reports channel completion
- done_ch  in  CH_BITS  completed channel
- dma_warp_stall  out  NUM_WARPS  per-warp stall to scheduler
- busy  out  1  FIFO non-empty or any channel allocated

## Operation
- Transfer ops (G2L/L2G):
  - size≠0: pushed into FIFO; outstanding[wid] is incremented on acceptance.
  - size==0: accepted and dropped; no count change.
- WAIT:
  - Never enters the FIFO.
  - On acceptance, if the post-update outstanding[wid]≠0, set wait_pending[wid]; otherwise it is a no-op.
- Ready rules:
  - req_ready = !fifo_full for transfer ops and 1 for WAIT/reserved.
  - No bypass: when the FIFO is full, a same-cycle pop does not make req_ready=1.
- Dispatch:
  - eng_valid = fifo_non_empty && (any channel free).
  - eng_ch = lowest-index free channel.
  - On eng_valid&&eng_ready: pop the head, mark the channel busy, and record ch_wid[ch]=head wid.
  - Outputs stay stable while eng_valid&&!eng_ready.
- Completion:
  - done_valid frees channel done_ch and decrements outstanding[ch_wid[done_ch]].
  - A done on a free channel is ignored (simulation assertion fires).
- Same-cycle events:
  - Increment and decrement for the same warp in one cycle leave the count unchanged.
  - A channel freed in cycle N is dispatchable in N+1.
  - A WAIT accepted in the same cycle as the done that zeroes that warp's count does not set wait_pending.
- wait_pending[w] clears when outstanding[w] becomes 0.
- dma_warp_stall = wait_pending (registered).
- Counters cannot overflow, because the maximum outstanding count is QUEUE_SIZE+NUM_CHANNELS.

## Timing
- Reset values:
  - FIFO empty, all channels free, all counters 0, wait_pending 0.
  - eng_valid=0, dma_warp_stall=0, busy=0, req_ready=1.
- Reset asserted mid-operation discards every queued and in-flight command immediately (asynchronous clear).
- Command accepted at cycle N → earliest eng_valid at N+1; throughput is 1 dispatch/cycle.
- WAIT accepted at N with pending transfers → dma_warp_stall[wid]=1 at N+1.
- Last done for that warp at M → stall=0 at M+1.
- busy is registered-state derived: it goes high at N+1 after the first accept and low the cycle after the last done with the FIFO empty.

## Structure
- VX_gpu_pkg holds:
  - DMA_OP_G2L/L2G/WAIT constants
  - dma_cmd_t {wid, dir, gaddr, laddr, size}
  - these types are shared with the SFU DMA unit and VX_dma_engine.
- Sub-modules:
  - VX_fifo_queue (existing) for the command FIFO, DATAW=$bits(dma_cmd_t), DEPTH=QUEUE_SIZE.
  - VX_priority_encoder (existing) for free-channel selection.
- Local state: ch_busy[NUM_CHANNELS], ch_wid[NUM_CHANNELS], outstanding[NUM_WARPS], wait_pending[NUM_WARPS].

## Test plan
- Single G2L, wid=2, size=64, eng_ready=1:
  - eng_valid at N+1 with eng_ch=0 and matching fields; outstanding[2]=1.
  - done_ch=0 → outstanding[2]=0, busy low next cycle.
- Five transfers from wid=0, NUM_CHANNELS=4, no dones:
  - Channels 0,1,2,3 dispatched in order; the 5th is held with eng_valid=0.
  - done_ch=2 → 5th dispatched on channel 2 one cycle later.
- WAIT from wid=1 with 2 outstanding:
  - stall[1]=1 at the next cycle and stays high after the first done.
  - Goes low one cycle after the second done.
  - WAIT with 0 outstanding → stall never asserts.
- FIFO full (16 queued, eng_ready=0):
  - req_ready=0 for G2L but 1 for WAIT.
  - Pop with simultaneous push attempt → push rejected that cycle and accepted the next.
- Same-cycle accept of a transfer and done for the same wid=3 → outstanding[3] unchanged. size=0 transfer → no dispatch, count unchanged.
- Async reset asserted between clock edges with 3 in flight → all outputs at reset values immediately; after release, new command dispatches on channel 0.
